// File: rtl/vote_pkg.sv
// Shared definitions for the vote sequencer: FSM state encoding and the
// majority threshold helper used by the tally and the sequencer.
package vote_pkg;

    // Round sequencing states. ST_ prefix keeps them apart from port names.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_TALLY  = 2'b10,
        ST_RESULT = 2'b11
    } vote_state_e;

    // Smallest count that forms a strict majority of n_voters (n_voters odd).
    function automatic int unsigned majority_threshold(input int unsigned n_voters);
        return (n_voters + 1) / 2;
    endfunction

endpackage

// File: rtl/vote_sequencer_majority_tally.sv
// majority_tally: combinational popcount of a ballot vector masked by a
// valid vector. Produces yes/no counts and the majority decision.
module majority_tally
    import vote_pkg::*;
#(
    parameter int unsigned N_VOTERS = 3
) (
    input  logic [N_VOTERS-1:0]               ballot_i,
    input  logic [N_VOTERS-1:0]               valid_i,
    output logic [$clog2(N_VOTERS+1)-1:0]     yes_count_o,
    output logic [$clog2(N_VOTERS+1)-1:0]     no_count_o,
    output logic                              majority_o
);

    localparam int unsigned CNT_W = $clog2(N_VOTERS + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(majority_threshold(N_VOTERS));

    logic [CNT_W-1:0] yes_v;
    logic [CNT_W-1:0] no_v;

    // Count valid yes and valid no ballots; invalid (missing) ballots count nowhere.
    always_comb begin
        yes_v = '0;
        no_v  = '0;
        for (int unsigned i = 0; i < N_VOTERS; i++) begin
            if (valid_i[i]) begin
                if (ballot_i[i]) yes_v = yes_v + CNT_W'(1);
                else             no_v  = no_v  + CNT_W'(1);
            end
        end
    end

    assign yes_count_o = yes_v;
    assign no_count_o  = no_v;
    assign majority_o  = (yes_v >= THRESH);

endmodule

// File: rtl/vote_sequencer.sv
// vote_sequencer: runs one timed voting round. START opens a window,
// each voter's first ballot is latched, the window closes on all-voted or
// expiry, the majority is tallied and held on RESULT with RESULT_VALID
// pulsed for HOLD_CYCLES.
// Optional build macro VOTE_EARLY_DECIDE_EN: close the window as soon as
// the outcome is decided by the ballots latched so far.
module vote_sequencer
    import vote_pkg::*;
#(
    parameter int unsigned N_VOTERS      = 3,
    parameter int unsigned WINDOW_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                START,
    input  logic [N_VOTERS-1:0] VOTE_STB,
    input  logic [N_VOTERS-1:0] VOTE_VAL,
    output logic                BUSY,
    output logic [N_VOTERS-1:0] VOTED,
    output logic                RESULT,
    output logic                RESULT_VALID,
    output logic                TIMEOUT
);

    localparam int unsigned CNT_W  = $clog2(N_VOTERS + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N_VOTERS);

    vote_state_e          state_q;
    logic [N_VOTERS-1:0]  voted_q;
    logic [N_VOTERS-1:0]  ballots_q;
    logic [WIN_W-1:0]     win_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 busy_q;
    logic                 result_q;
    logic                 valid_q;
    logic                 timeout_q;

    logic [N_VOTERS-1:0]  accept;
    logic [N_VOTERS-1:0]  voted_d;
    logic [N_VOTERS-1:0]  ballots_d;
    logic [CNT_W-1:0]     yes_count;
    logic [CNT_W-1:0]     no_count;
    logic                 majority;
    logic                 all_voted;

    // Accept first strobes only while OPEN; next-state ballot/voted vectors.
    always_comb begin
        accept    = (state_q == ST_OPEN) ? (VOTE_STB & ~voted_q) : '0;
        voted_d   = voted_q | accept;
        ballots_d = (ballots_q & ~accept) | (VOTE_VAL & accept);
    end

    // Tally on the next-state vectors so this cycle's ballots are seen at
    // once; outside OPEN these equal the registered ballots.
    majority_tally #(
        .N_VOTERS (N_VOTERS)
    ) u_tally (
        .ballot_i    (ballots_d),
        .valid_i     (voted_d),
        .yes_count_o (yes_count),
        .no_count_o  (no_count),
        .majority_o  (majority)
    );

    // Every voter has a ballot exactly when the yes and no counts cover all voters.
    assign all_voted = ((yes_count + no_count) == N_CNT);

`ifdef VOTE_EARLY_DECIDE_EN
    logic decided;
    // Outcome is fixed once either side reaches the majority threshold.
    assign decided = (yes_count >= CNT_W'(majority_threshold(N_VOTERS))) ||
                     (no_count  >= CNT_W'(majority_threshold(N_VOTERS)));
`endif

    // Round sequencer with registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            voted_q   <= '0;
            ballots_q <= '0;
            win_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            result_q  <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q   <= ST_OPEN;
                        busy_q    <= 1'b1;
                        voted_q   <= '0;
                        ballots_q <= '0;
                        timeout_q <= 1'b0;
                        win_q     <= WIN_LOAD;
                    end
                end
                ST_OPEN: begin
                    voted_q   <= voted_d;
                    ballots_q <= ballots_d;
                    if (all_voted) begin
                        state_q <= ST_TALLY;
`ifdef VOTE_EARLY_DECIDE_EN
                    end else if (decided) begin
                        state_q <= ST_TALLY;
`endif
                    end else if (win_q == '0) begin
                        state_q   <= ST_TALLY;
                        timeout_q <= 1'b1;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                    end
                end
                ST_TALLY: begin
                    result_q <= majority;
                    valid_q  <= 1'b1;
                    hold_q   <= HOLD_LOAD;
                    state_q  <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (hold_q == '0) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY         = busy_q;
    assign VOTED        = voted_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_vote_sequencer.sv
// Bench for vote_sequencer: directed and randomized rounds compared each
// cycle against a round-level reference model (first-strobe times per voter).
module tb_vote_sequencer;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int H   = 4;
    localparam int T   = (N + 1) / 2;
    localparam int LEN = W + H + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] vote_stb;
    logic [N-1:0] vote_val;
    logic         busy;
    logic [N-1:0] voted;
    logic         result;
    logic         result_valid;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] stb_a [LEN];
    logic [N-1:0] val_a [LEN];
    logic         st_a  [LEN];
    logic         prev_result;

    always #5 clk = ~clk;

    vote_sequencer #(
        .N_VOTERS      (N),
        .WINDOW_CYCLES (W),
        .HOLD_CYCLES   (H)
    ) dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .START        (start),
        .VOTE_STB     (vote_stb),
        .VOTE_VAL     (vote_val),
        .BUSY         (busy),
        .VOTED        (voted),
        .RESULT       (result),
        .RESULT_VALID (result_valid),
        .TIMEOUT      (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < LEN; k++) begin
            stb_a[k] = '0;
            val_a[k] = '0;
            st_a[k]  = 1'b0;
        end
    endtask

    task automatic rand_stim();
        int unsigned dens;
        logic [N-1:0] s;
        dens = $urandom_range(0, 5);
        for (int k = 0; k < LEN; k++) begin
            for (int i = 0; i < N; i++) s[i] = ($urandom_range(0, 15) < dens);
            stb_a[k] = s;
            val_a[k] = N'($urandom);
            st_a[k]  = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Yes/no counts of ballots whose first strobe came at or before cycle k.
    function automatic void tally_at(input int f[N], input int k, output int y, output int n);
        y = 0;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (f[i] <= k) begin
                if (val_a[f[i]][i]) y++;
                else                n++;
            end
        end
    endfunction

    task automatic run_round();
        int first [N];
        int maxf, close, y, n;
        bit decided, to;
        logic er;
        logic [N-1:0] ev;

        // Reference: each voter's ballot is the value at its first strobe.
        maxf = 0;
        for (int i = 0; i < N; i++) begin
            first[i] = LEN;
            for (int k = 0; k < LEN; k++)
                if (stb_a[k][i] && first[i] == LEN) first[i] = k;
            if (first[i] > maxf) maxf = first[i];
        end
        close = (maxf <= W - 1) ? maxf : W - 1;
`ifdef VOTE_EARLY_DECIDE_EN
        for (int k = 0; k <= close; k++) begin
            tally_at(first, k, y, n);
            if (y >= T || n >= T) begin
                close = k;
                break;
            end
        end
`endif
        tally_at(first, close, y, n);
`ifdef VOTE_EARLY_DECIDE_EN
        decided = (y >= T || n >= T);
`else
        decided = 1'b0;
`endif
        to = !(maxf <= close) && !decided;
        er = (y >= T);

        // Junk strobes while IDLE must be ignored.
        @(negedge clk);
        start    = 1'b1;
        vote_stb = N'($urandom);
        vote_val = N'($urandom);
        for (int c = 0; c <= close + 2 + H; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) ev[i] = (first[i] < c) && (first[i] <= close);
            check_eq($sformatf("busy@%0d", c),    32'(busy),         32'(c <= close + 1 + H));
            check_eq($sformatf("valid@%0d", c),   32'(result_valid), 32'(c >= close + 2 && c <= close + 1 + H));
            check_eq($sformatf("voted@%0d", c),   32'(voted),        32'(ev));
            check_eq($sformatf("timeout@%0d", c), 32'(timeout),      32'((c >= close + 1) ? to : 1'b0));
            check_eq($sformatf("result@%0d", c),  32'(result),       32'((c >= close + 2) ? er : prev_result));
            vote_stb = stb_a[c];
            vote_val = val_a[c];
            start    = (c <= close + 1 + H) ? st_a[c] : 1'b0;
        end
        start       = 1'b0;
        vote_stb    = '0;
        prev_result = er;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        vote_stb    = '0;
        vote_val    = '0;
        prev_result = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",    32'(busy),         32'd0);
        check_eq("rst_voted",   32'(voted),        32'd0);
        check_eq("rst_result",  32'(result),       32'd0);
        check_eq("rst_valid",   32'(result_valid), 32'd0);
        check_eq("rst_timeout", 32'(timeout),      32'd0);
        rst = 1'b0;

        // Ballots 1,1,0 on consecutive cycles.
        clear_stim();
        stb_a[0] = 3'b001; val_a[0] = 3'b001;
        stb_a[1] = 3'b010; val_a[1] = 3'b010;
        stb_a[2] = 3'b100; val_a[2] = 3'b000;
        run_round();

        // Voter0 re-strobes with 0; voters 1,2 vote 0 together.
        clear_stim();
        stb_a[0] = 3'b001; val_a[0] = 3'b001;
        stb_a[1] = 3'b111; val_a[1] = 3'b000;
        run_round();

        // Only voter0 votes; window expires.
        clear_stim();
        stb_a[0] = 3'b001; val_a[0] = 3'b001;
        run_round();

        // Last ballot lands on the final window cycle; START during RESULT.
        clear_stim();
        stb_a[0]     = 3'b001; val_a[0]     = 3'b001;
        stb_a[3]     = 3'b010; val_a[3]     = 3'b000;
        stb_a[W - 1] = 3'b100; val_a[W - 1] = 3'b100;
        st_a[W + 2]  = 1'b1;
        run_round();

        // Voters 0 and 2 vote yes together.
        clear_stim();
        stb_a[0] = 3'b101; val_a[0] = 3'b101;
        run_round();

        // Reset in the middle of an open window.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        vote_stb = 3'b001;
        vote_val = 3'b001;
        @(negedge clk);
        vote_stb = '0;
        check_eq("mid_busy",  32'(busy),  32'd1);
        check_eq("mid_voted", 32'(voted), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy",    32'(busy),    32'd0);
        check_eq("abort_voted",   32'(voted),   32'd0);
        check_eq("abort_timeout", 32'(timeout), 32'd0);
        check_eq("abort_result",  32'(result),  32'd0);
        for (int c = 0; c < W + H + 4; c++) begin
            check_eq($sformatf("abort_valid@%0d", c), 32'(result_valid), 32'd0);
            @(negedge clk);
        end
        check_eq("abort_idle", 32'(busy), 32'd0);
        prev_result = 1'b0;

        for (int r = 0; r < 40; r++) begin
            rand_stim();
            run_round();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
